// File: rtl/fp_cvt_widen.sv
// fp_cvt_widen: exact widening float conversion ({sign,exp,sig} to a wider
// {sign,exp,sig}) in a three-stage valid/ready pipeline.
// S1 unpacks and classifies. S2 counts leading zeros and normalises subnormals.
// S3 rebiases the exponent and packs the result.
// Build option FPCVT_DENORM_EN:
//   defined   - subnormal inputs are normalised into destination normals.
//   undefined - subnormal inputs flush to signed zero (denorm+zero flags),
//               and no leading-zero counter is built.
module fp_cvt_widen #(
    parameter int EXP_I = 11,
    parameter int SIG_I = 52,
    parameter int EXP_O = 15,
    parameter int SIG_O = 80,
    parameter int TAGW  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_I+SIG_I:0]   in_data,
    input  logic [TAGW-1:0]        in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_O+SIG_O:0]   out_data,
    output logic [TAGW-1:0]        out_tag,
    output logic [2:0]             out_flags
);

    localparam int BIAS_I    = (1 << (EXP_I - 1)) - 1;
    localparam int BIAS_O    = (1 << (EXP_O - 1)) - 1;
    localparam int BIAS_DIFF = BIAS_O - BIAS_I;
    localparam logic [EXP_O-1:0] BIAS_DIFF_V = EXP_O'(BIAS_DIFF);

    // Refuse to build a configuration that cannot represent every source value exactly.
    if (EXP_O < EXP_I) begin : g_err_exp
        $error("fp_cvt_widen: EXP_O must be >= EXP_I");
    end
    if (SIG_O < SIG_I) begin : g_err_sig
        $error("fp_cvt_widen: SIG_O must be >= SIG_I");
    end
    if (BIAS_DIFF - (SIG_I - 1) < 1) begin : g_err_bias
        $error("fp_cvt_widen: smallest subnormal does not map to a destination normal");
    end

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_SUB  = 2'd2,
        CLS_SPEC = 2'd3
    } cls_e;

    // Stage occupancy and handshakes.
    logic r_s1_v, r_s2_v, r_s3_v;
    logic w_s3_free, w_s2_free, w_s1_free, w_s2_move, w_s1_move, w_in_fire;

    assign w_s3_free = !r_s3_v || out_ready;
    assign w_s2_free = !r_s2_v || w_s3_free;
    assign w_s1_free = !r_s1_v || w_s2_free;
    assign w_s2_move = r_s2_v && w_s3_free;
    assign w_s1_move = r_s1_v && w_s2_free;
    assign in_ready  = rst_n && w_s1_free;
    assign w_in_fire = in_valid && in_ready;

    // S1: unpack and classify.
    logic               w_in_sign;
    logic [EXP_I-1:0]   w_in_exp;
    logic [SIG_I-1:0]   w_in_sig;
    cls_e               w_in_cls;

    assign w_in_sign = in_data[EXP_I+SIG_I];
    assign w_in_exp  = in_data[SIG_I +: EXP_I];
    assign w_in_sig  = in_data[SIG_I-1:0];

    // Classify the incoming operand by exponent/significand pattern.
    always_comb begin
        w_in_cls = CLS_NORM;
        if (w_in_exp == '1) begin
            w_in_cls = CLS_SPEC;
        end else if (w_in_exp == '0) begin
            if (w_in_sig == '0) begin
                w_in_cls = CLS_ZERO;
            end else begin
                w_in_cls = CLS_SUB;
            end
        end else begin
            w_in_cls = CLS_NORM;
        end
    end

    logic               r_s1_sign, r_s2_sign;
    logic [EXP_I-1:0]   r_s1_exp,  r_s2_exp;
    logic [SIG_I-1:0]   r_s1_sig,  r_s2_sig;
    logic [TAGW-1:0]    r_s1_tag,  r_s2_tag;
    cls_e               r_s1_cls,  r_s2_cls;

    // S1 register: accepts a new operand whenever the stage is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_exp  <= '0;
            r_s1_sig  <= '0;
            r_s1_tag  <= '0;
            r_s1_cls  <= CLS_NORM;
        end else begin
            if (w_s1_free) begin
                r_s1_v <= in_valid;
            end
            if (w_in_fire) begin
                r_s1_sign <= w_in_sign;
                r_s1_exp  <= w_in_exp;
                r_s1_sig  <= w_in_sig;
                r_s1_tag  <= in_tag;
                r_s1_cls  <= w_in_cls;
            end
        end
    end

    // S2: leading-zero count and normalisation of subnormals.
    logic [SIG_I-1:0] w_s2_sig;

`ifdef FPCVT_DENORM_EN
    localparam int LZW = $clog2(SIG_I + 1);

    // Leading zeros of v; the highest set bit wins because it is visited last.
    function automatic logic [LZW-1:0] lzc(input logic [SIG_I-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(SIG_I);
        for (int i = 0; i < SIG_I; i++) begin
            n = v[i] ? LZW'(SIG_I - 1 - i) : n;
        end
        return n;
    endfunction

    logic [LZW-1:0] w_lz;
    logic [LZW-1:0] r_s2_lz;

    // Shift out the leading zeros and the hidden one of a subnormal.
    always_comb begin
        w_lz = lzc(r_s1_sig);
        if (r_s1_cls == CLS_SUB) begin
            w_s2_sig = {r_s1_sig[SIG_I-2:0], 1'b0} << w_lz;
        end else begin
            w_s2_sig = r_s1_sig;
        end
    end

    // S2 extra state: leading-zero count carried to the rebias stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_lz <= '0;
        end else if (w_s1_move) begin
            r_s2_lz <= w_lz;
        end
    end
`else
    assign w_s2_sig = r_s1_sig;
`endif

    // S2 register: takes the S1 entry when S1 advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v    <= 1'b0;
            r_s2_sign <= 1'b0;
            r_s2_exp  <= '0;
            r_s2_sig  <= '0;
            r_s2_tag  <= '0;
            r_s2_cls  <= CLS_NORM;
        end else begin
            if (w_s2_free) begin
                r_s2_v <= r_s1_v;
            end
            if (w_s1_move) begin
                r_s2_sign <= r_s1_sign;
                r_s2_exp  <= r_s1_exp;
                r_s2_sig  <= w_s2_sig;
                r_s2_tag  <= r_s1_tag;
                r_s2_cls  <= r_s1_cls;
            end
        end
    end

    // S3: rebias and pack.
    logic [EXP_O-1:0] w_exp_ext, w_exp_o;
    logic [SIG_O-1:0] w_sig_ext, w_sig_o;
    logic [2:0]       w_flags;

    // Build destination exponent, significand and flags per input class.
    always_comb begin
        w_exp_ext = '0;
        w_exp_ext[EXP_I-1:0] = r_s2_exp;
        w_sig_ext = '0;
        w_sig_ext[SIG_O-1 -: SIG_I] = r_s2_sig;
        w_exp_o = '0;
        w_sig_o = '0;
        w_flags = 3'b000;
        case (r_s2_cls)
            CLS_NORM: begin
                w_exp_o = w_exp_ext + BIAS_DIFF_V;
                w_sig_o = w_sig_ext;
            end
            CLS_ZERO: begin
                w_flags = 3'b001;
            end
            CLS_SUB: begin
`ifdef FPCVT_DENORM_EN
                w_exp_o = BIAS_DIFF_V - EXP_O'(r_s2_lz);
                w_sig_o = w_sig_ext;
                w_flags = 3'b010;
`else
                w_flags = 3'b011;
`endif
            end
            CLS_SPEC: begin
                w_exp_o = '1;
                w_sig_o = w_sig_ext;
                if (r_s2_sig != '0) begin
                    w_sig_o[SIG_O-1] = 1'b1;
                    w_flags = {~r_s2_sig[SIG_I-1], 2'b00};
                end else begin
                    w_flags = 3'b000;
                end
            end
            default: begin
                w_exp_o = '0;
                w_sig_o = '0;
                w_flags = 3'b000;
            end
        endcase
    end

    logic [EXP_O+SIG_O:0] r_out_data;
    logic [TAGW-1:0]      r_out_tag;
    logic [2:0]           r_out_flags;

    // S3 register: holds the packed result until the sink takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_v      <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_flags <= 3'b000;
        end else begin
            if (w_s3_free) begin
                r_s3_v <= r_s2_v;
            end
            if (w_s2_move) begin
                r_out_data  <= {r_s2_sign, w_exp_o, w_sig_o};
                r_out_tag   <= r_s2_tag;
                r_out_flags <= w_flags;
            end
        end
    end

    assign out_valid = r_s3_v;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign out_flags = r_out_flags;

endmodule

// File: doc/fp_cvt_widen.md
FP_CVT_WIDEN -- requirements
Module: fp_cvt_widen

Interface
REQ-001 Parameter EXP_I, default 11, meaning source exponent width.
REQ-002 Parameter SIG_I, default 52, meaning source stored-significand width.
REQ-003 Parameter EXP_O, default 15, meaning destination exponent width; SHALL be >= EXP_I.
REQ-004 Parameter SIG_O, default 80, meaning destination significand width; SHALL be >= SIG_I.
REQ-005 Parameter TAGW, default 4, meaning sideband tag width carried alongside data.
REQ-006 clk  in  1  clock; one clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset; asynchronous, active-low.
REQ-008 in_valid  in  1  source operand present.
REQ-009 in_ready  out  1  block accepts operand this cycle.
REQ-010 in_data  in  1+EXP_I+SIG_I  packed {sign,exp,sig} source float.
REQ-011 in_tag  in  TAGW  opaque tag.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  sink accepts result.
REQ-014 out_data  out  1+EXP_O+SIG_O  packed {sign,exp,sig} destination float.
REQ-015 out_tag  out  TAGW  tag of the operand that produced out_data.
REQ-016 out_flags  out  3  {invalid (sNaN input), denorm (subnormal input), zero (zero output)}.

Function
REQ-017 Pipeline SHALL have three registered stages: S1 unpack/classify, S2 leading-zero count and normalise, S3 rebias and pack; latency SHALL be exactly 3 cycles with no stall.
REQ-018 Each stage SHALL hold one entry with its own valid bit; stage k advances when stage k+1 is empty or advancing; S3 advances when out_ready=1.
REQ-019 in_ready SHALL equal (!S1.valid || S1 advancing); transfer occurs only when in_valid && in_ready.
REQ-020 Under stall, held entries, tags and flags SHALL remain stable; results SHALL leave in acceptance order; no loss, no duplication.
REQ-021 Full throughput: one result per cycle with in_valid=out_ready=1 continuously; capacity three entries when out_ready=0.
REQ-022 Sign SHALL pass through unchanged in all classes.
REQ-023 Normal input: exp_o = exp_i + (2^(EXP_O-1)-1) - (2^(EXP_I-1)-1); sig_o = {sig_i, (SIG_O-SIG_I) zeros}.
REQ-024 exp_i all ones: exp_o all ones; sig_i zero yields infinity with sig_o zero.
REQ-025 NaN: sig_o = {sig_i, zeros} with sig_o MSB forced to 1; invalid flag set when sig_i MSB was 0 (sNaN).
REQ-026 Zero (exp_i=0, sig_i=0): out exp and sig zero, zero flag set.
REQ-027 Subnormal (exp_i=0, sig_i!=0), lz = leading zeros of sig_i: sig_o = {(sig_i << (lz+1)) truncated to SIG_I, zeros}; exp_o = bias_o - bias_i - lz; denorm flag set.
REQ-028 Parameters SHALL satisfy bias_o - bias_i - (SIG_I-1) >= 1 so subnormals become destination normals; elaboration SHALL fail otherwise.
REQ-029 Conversion SHALL be exact; no rounding logic, no inexact flag.

Reset
REQ-030 While rst_n=0 all stage valid bits SHALL clear asynchronously; out_valid=0, out_flags=0, out_data=0, out_tag=0.
REQ-031 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after deassertion.
REQ-032 Reset mid-operation SHALL discard all in-flight entries; none SHALL appear after release.

Configuration
REQ-033 Macro FPCVT_DENORM_EN defined: subnormals normalised per REQ-027 using S2 leading-zero counter.
REQ-034 Macro FPCVT_DENORM_EN undefined: subnormals flush to signed zero (exp_o=0, sig_o=0), denorm and zero flags both set, counter not instantiated; latency still 3.

Verification
REQ-035 in_data=0x3FF0000000000000 -> after 3 cycles out exp=0x3FFF, sig=0, sign=0, flags=000.
REQ-036 in_data=0xFFF0000000000000 -> sign=1, exp=0x7FFF, sig=0, flags=000; in_data=0x7FF0000000000001 -> exp=0x7FFF, sig MSB=1, sig LSB field = 1<<28, invalid=1.
REQ-037 in_data=0x0000000000000001 with FPCVT_DENORM_EN -> exp=0x3BCD, sig=0, denorm=1; without macro -> exp=0, sig=0, flags=011.
REQ-038 out_ready=0 for 6 cycles, in_valid=1 with tags 1..5 -> in_ready low after 3 accepts; on out_ready=1 outputs emerge tags 1,2,3,4,5 in order, one per cycle.
REQ-039 rst_n pulsed low with 3 entries in flight -> out_valid=0 immediately, no result emerges after release, in_ready=1 next cycle.
